// File: rtl/tick_pwm_generator.sv
// tick_pwm_generator: counts qualified strobe ticks into a programmable
// period and drives pwm_out high for the first `duty` ticks of each period.
// New period/duty values are staged in a shadow register and promoted to
// the active register only at a period boundary (wrap, enable rise) or
// while idle, so a running period is never truncated or mixed.
//
// Config handshake (valid/ready):
//   - A transfer happens on any rising clk_in edge where cfg_valid and
//     cfg_ready are both high; cfg_period/cfg_duty are sampled on that edge.
//   - cfg_ready is !pending: it drops the cycle after a transfer and rises
//     again the cycle after the shadow is promoted to the active register.
//   - cfg_valid while cfg_ready is low is ignored; nothing is stalled or
//     overwritten, and the upstream may keep or withdraw its offer freely.
module tick_pwm_generator #(
  parameter int WIDTH          = 8,
  parameter int DEFAULT_PERIOD = 10,
  parameter int DEFAULT_DUTY   = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_start
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF_PER  = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] DEF_DUTY = WIDTH'(DEFAULT_DUTY);

  // Architectural state
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] active_period;
  logic [WIDTH-1:0] active_duty;
  logic [WIDTH-1:0] shadow_period;
  logic [WIDTH-1:0] shadow_duty;
  logic             pending;
  logic             en_d;

  // Next-state values
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] active_period_next;
  logic [WIDTH-1:0] active_duty_next;
  logic [WIDTH-1:0] shadow_period_next;
  logic [WIDTH-1:0] shadow_duty_next;
  logic             pending_next;
  logic             pwm_next;
  logic             period_start_next;

  // Decoded events
  logic accept;
  logic qual_tick;
  logic en_rise;
  logic at_last;
  logic wrap;
  logic boundary;

  assign cfg_ready = !pending;
  assign accept    = cfg_valid && cfg_ready;
  assign qual_tick = tick_in && enable;
  assign en_rise   = enable && !en_d;
  // active_period is always >= 1 (clamped on capture), so the subtraction
  // never underflows and count can never run past the last tick.
  assign at_last   = (count == (active_period - ONE));
  assign wrap      = qual_tick && at_last && !en_rise;
  assign boundary  = enable && (wrap || en_rise);

  // Next-state logic: counter, shadow capture, boundary promotion, outputs
  always_comb begin
    count_next         = count;
    active_period_next = active_period;
    active_duty_next   = active_duty;
    shadow_period_next = shadow_period;
    shadow_duty_next   = shadow_duty;
    pending_next       = pending;
    period_start_next  = 1'b0;

    // Promotion uses the pending flag from before this edge, so a config
    // accepted on a wrap edge waits for the following boundary.
    if (!enable) begin
      count_next = '0;
      if (pending) begin
        active_period_next = shadow_period;
        active_duty_next   = shadow_duty;
        pending_next       = 1'b0;
      end
    end else begin
      if (en_rise) begin
        // Enable rise restarts the period from zero; a coincident tick is
        // absorbed into the restart.
        count_next = '0;
      end else if (qual_tick) begin
        count_next = at_last ? '0 : (count + ONE);
      end
      if (boundary) begin
        period_start_next = 1'b1;
        if (pending) begin
          active_period_next = shadow_period;
          active_duty_next   = shadow_duty;
          pending_next       = 1'b0;
        end
      end
    end

    // A transfer is only possible while pending is low, so it never
    // collides with the promotion above.
    if (accept) begin
      shadow_period_next = (cfg_period == '0) ? ONE : cfg_period;
      shadow_duty_next   = cfg_duty;
      pending_next       = 1'b1;
    end

    pwm_next = enable && (count_next < active_duty_next);
  end

  // State and registered outputs, asynchronously returned to defaults
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count         <= '0;
      active_period <= DEF_PER;
      active_duty   <= DEF_DUTY;
      shadow_period <= DEF_PER;
      shadow_duty   <= DEF_DUTY;
      pending       <= 1'b0;
      en_d          <= 1'b0;
      pwm_out       <= 1'b0;
      period_start  <= 1'b0;
    end else begin
      count         <= count_next;
      active_period <= active_period_next;
      active_duty   <= active_duty_next;
      shadow_period <= shadow_period_next;
      shadow_duty   <= shadow_duty_next;
      pending       <= pending_next;
      en_d          <= enable;
      pwm_out       <= pwm_next;
      period_start  <= period_start_next;
    end
  end

endmodule

// File: tb/tb_tick_pwm_generator.sv
// Bench for tick_pwm_generator. The driver applies one cycle of inputs at a
// time and pushes the outputs expected after the following rising edge;
// the monitor pops and compares on each falling edge.
module tb_tick_pwm_generator;

  localparam int W = 22;  // {step[15:0], mask[2:0], pwm, period_start, ready}

  // ---------------- clock / reset ----------------
  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_period = '0;
  logic [7:0] cfg_duty = '0;
  logic       cfg_ready;
  logic       pwm_out;
  logic       period_start;

  always #5 clk_in = ~clk_in;

  tick_pwm_generator #(
    .WIDTH(8),
    .DEFAULT_PERIOD(10),
    .DEFAULT_DUTY(5)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .tick_in(tick_in),
    .enable(enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_period(cfg_period),
    .cfg_duty(cfg_duty),
    .pwm_out(pwm_out),
    .period_start(period_start)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  int step     = 0;

  task automatic chk(input string name, input int stp, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s step=%0d got=%b expected=%b", name, stp, got, exp);
    end
  endtask

  // Monitor: compares DUT outputs with the oldest expectation
  always @(negedge clk_in) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[5]) chk("pwm_out", int'(e[21:6]), pwm_out, e[2]);
      if (e[4]) chk("period_start", int'(e[21:6]), period_start, e[1]);
      if (e[3]) chk("cfg_ready", int'(e[21:6]), cfg_ready, e[0]);
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle of stimulus plus the outputs expected after its edge.
  task automatic cyc(input bit t, input bit en, input bit cv,
                     input logic [7:0] cp, input logic [7:0] cd,
                     input bit [2:0] m, input bit ep, input bit es, input bit er);
    logic [15:0] s;
    @(negedge clk_in);
    #1;
    tick_in    = t;
    enable     = en;
    cfg_valid  = cv;
    cfg_period = cp;
    cfg_duty   = cd;
    step++;
    s = 16'(step);
    exp_q.push_back({s, m, ep, es, er});
  endtask

  // One full period from count 0 with a tick every `gap` cycles.
  // Expected waveform: after tick j the count is j mod p, so pwm is
  // (j mod p) < d, except on the wrap where duty `dn` of the next period
  // applies. Optionally offers a config on the tick cycle of tick inj_j.
  task automatic period_run(input int p, input int d, input int gap, input int inj_j,
                            input logic [7:0] ip, input logic [7:0] id,
                            input bit rpre, input bit rpost, input bit rwrap,
                            input int dn);
    bit cur, nw, injected, inj;
    int cnt;
    cur = (0 < d);
    injected = 1'b0;
    for (int j = 1; j <= p; j++) begin
      for (int g = 1; g < gap; g++)
        cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 3'b111, cur, 1'b0, injected ? rpost : rpre);
      cnt = j % p;
      nw  = (j == p) ? (0 < dn) : (cnt < d);
      inj = (j == inj_j);
      if (inj) injected = 1'b1;
      cyc(1'b1, 1'b1, inj, ip, id, 3'b111, nw, (j == p),
          (j == p) ? rwrap : (injected ? rpost : rpre));
      cur = nw;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'b111, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'd3, 8'd3, 3'b111, 1'b0, 1'b0, 1'b1);
    @(posedge clk_in);
    #1 rst = 1'b0;

    // Defaults: 10 ticks, 5 high, tick every 4 cycles
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 3'b111, 1'b1, 1'b1, 1'b1);
    period_run(10, 5, 4, 0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 5);
    period_run(10, 5, 4, 0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 5);

    // Boundary update: 4/1 accepted mid-period
    period_run(10, 5, 4, 3, 8'd4, 8'd1, 1'b1, 1'b0, 1'b1, 1);
    period_run(4, 1, 4, 0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1);

    // Extremes: duty 0, duty above period, period 0
    period_run(4, 1, 4, 2, 8'd8, 8'd0, 1'b1, 1'b0, 1'b1, 0);
    period_run(8, 0, 2, 1, 8'd8, 8'd12, 1'b1, 1'b0, 1'b1, 12);
    period_run(8, 12, 2, 5, 8'd0, 8'd1, 1'b1, 1'b0, 1'b1, 1);
    period_run(1, 1, 3, 0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1);
    period_run(1, 1, 3, 0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1);

    // Collision: config on the wrap tick uses old values for one period
    period_run(1, 1, 3, 1, 8'd6, 8'd2, 1'b1, 1'b0, 1'b0, 1);
    period_run(1, 1, 3, 0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 2);
    period_run(6, 2, 2, 6, 8'd3, 8'd3, 1'b1, 1'b0, 1'b0, 2);
    // Offer while not ready is ignored
    period_run(6, 2, 2, 2, 8'd9, 8'd9, 1'b0, 1'b0, 1'b1, 3);
    period_run(3, 3, 2, 0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 3);

    // Enable toggling
    cyc(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 3'b111, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'b111, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'd4, 8'd2, 3'b111, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'b111, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 3'b111, 1'b1, 1'b1, 1'b1);
    period_run(4, 2, 2, 0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 2);

    // Async reset mid-period with a pending shadow
    cyc(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 3'b111, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'd7, 8'd7, 3'b111, 1'b1, 1'b0, 1'b0);
    @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm", step, pwm_out, 1'b0);
    chk("async_rst_start", step, period_start, 1'b0);
    chk("async_rst_ready", step, cfg_ready, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 3'b111, 1'b0, 1'b0, 1'b1);
    @(posedge clk_in);
    #1 rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 3'b111, 1'b1, 1'b1, 1'b1);
    period_run(10, 5, 4, 0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 5);

    // Drain and report
    @(negedge clk_in);
    @(negedge clk_in);
    chk("queue_drained", step, 1'(exp_q.size() == 0), 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog step=%0d got=timeout expected=finish", step);
    $fatal(1, "watchdog expired");
  end

endmodule
